// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// Bytes enter over a Send/Ready handshake and leave LSB first on Tx.
module uart_transmitter #(
   parameter int unsigned          CNT_WIDTH = 14,
   parameter logic [CNT_WIDTH-1:0] BAUD_DIV  = 14'd9999,
   parameter int unsigned          DEPTH     = 4,
   parameter int unsigned          ADDR_W    = 2
) (
   input  logic       Clk_100M,
   input  logic       Reset,
   input  logic [7:0] Data,
   input  logic       Send,
   output logic       Ready,
   output logic       Busy,
   output logic       Tx
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

   state_t               state;
   state_t               state_nxt;

   logic [7:0]           mem [DEPTH];
   logic [ADDR_W-1:0]    rd_ptr;
   logic [ADDR_W-1:0]    wr_ptr;
   logic [ADDR_W:0]      count;

   logic [7:0]           shift;
   logic [2:0]           bit_idx;
   logic [CNT_WIDTH-1:0] baud_cnt;

   logic                 push;
   logic                 pop;
   logic                 term;
   logic                 tx_nxt;

   assign Ready = (count != FULL);
   assign push  = Send && Ready;
   assign term  = (baud_cnt == BAUD_DIV);
   assign Busy  = (state != IDLE) || (count != '0);

   // FIFO storage carries no reset; pointers and count define validity.
   always_ff @(posedge Clk_100M) begin
      if (push) begin
         mem[wr_ptr] <= Data;
      end
   end

   always_ff @(posedge Clk_100M or negedge Reset) begin
      if (!Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge Clk_100M or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (count != '0)               state_nxt = START;
         START: if (term)                      state_nxt = DATA;
         DATA:  if (term && bit_idx == 3'd7)   state_nxt = STOP;
         STOP:  if (term)                      state_nxt = IDLE;
      endcase
   end

   // Next Tx is decided here so the pin itself stays a plain register.
   always_comb begin
      tx_nxt = 1'b1;
      pop    = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               pop    = 1'b1;
               tx_nxt = 1'b0;
            end
         end
         START: tx_nxt = term ? shift[0] : 1'b0;
         DATA: begin
            if (term) begin
               tx_nxt = (bit_idx == 3'd7) ? 1'b1 : shift[1];
            end else begin
               tx_nxt = Tx;
            end
         end
         STOP: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge Clk_100M or negedge Reset) begin
      if (!Reset) begin
         Tx       <= 1'b1;
         shift    <= '0;
         bit_idx  <= '0;
         baud_cnt <= '0;
      end else begin
         Tx <= tx_nxt;

         if (state == IDLE || term) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end

         if (pop) begin
            shift <= mem[rd_ptr];
         end else if (state == DATA && term) begin
            shift <= {1'b0, shift[7:1]};
         end

         if (state == START && term) begin
            bit_idx <= '0;
         end else if (state == DATA && term) begin
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: random and directed traffic checked every cycle
// against a frame-timeline model of the line, FIFO occupancy and handshake.
module tb_uart_transmitter;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned BIT   = 4;
   localparam int unsigned FRAME = 10 * BIT;

   logic       clk;
   logic       rst_n;
   logic [7:0] data;
   logic       send;
   logic       ready;
   logic       busy;
   logic       tx;

   int unsigned total;
   int unsigned bad;

   uart_transmitter #(
      .CNT_WIDTH (14),
      .BAUD_DIV  (14'd3),
      .DEPTH     (DEPTH),
      .ADDR_W    (2)
   ) dut (
      .Clk_100M (clk),
      .Reset    (rst_n),
      .Data     (data),
      .Send     (send),
      .Ready    (ready),
      .Busy     (busy),
      .Tx       (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: queued bytes plus the position inside the frame on the line.
   logic [7:0]  m_q[$];
   logic        m_active;
   int unsigned m_e;
   logic [7:0]  m_cur;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_active = 1'b0;
         m_e      = 0;
         m_cur    = '0;
      end else begin
         logic room;
         room = (m_q.size() < DEPTH);
         if (m_active) begin
            m_e++;
            if (m_e == FRAME) m_active = 1'b0;
         end else if (m_q.size() != 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_e      = 0;
         end
         if (send && room) m_q.push_back(data);
      end
   end

   function automatic logic exp_tx();
      int unsigned b;
      if (!m_active) return 1'b1;
      b = m_e / BIT;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   always @(negedge clk) begin
      check("tx",    tx,    exp_tx());
      check("busy",  busy,  m_active || (m_q.size() != 0));
      check("ready", ready, m_q.size() < DEPTH);
   end

   task automatic wait_idle(input int unsigned budget);
      for (int unsigned i = 0; i < budget && busy; i++) @(negedge clk);
      if (busy) check("idle_timeout", busy, 1'b0);
   endtask

   initial begin
      logic [9:0] pat;
      bit         hit;

      total = 0;
      bad   = 0;
      send  = 1'b0;
      data  = '0;
      rst_n = 1'b0;

      // Reset held with Send toggling: nothing may be written.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         send = ~send;
         data = 8'($urandom);
         check("rst_tx",    tx,    1'b1);
         check("rst_ready", ready, 1'b1);
         check("rst_busy",  busy,  1'b0);
      end
      @(negedge clk);
      send  = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 1'b0);

      // Single byte 0xA5 with an explicit line pattern.
      send = 1'b1;
      data = 8'hA5;
      @(negedge clk);
      send = 1'b0;
      check("a5_pre", tx, 1'b1);
      @(negedge clk);
      pat = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 40; i++) begin
         check("a5_bit", tx, pat[i/4]);
         @(negedge clk);
      end
      check("a5_busy_low", busy, 1'b0);
      wait_idle(100);

      // Overflow: six consecutive sends, sixth is dropped.
      for (int i = 1; i <= 6; i++) begin
         send = 1'b1;
         data = 8'(i);
         @(negedge clk);
         if (i == 5) check("ovf_ready", ready, 1'b0);
      end
      send = 1'b0;
      wait_idle(400);

      // Back-to-back 0x00 then 0xFF.
      send = 1'b1;
      data = 8'h00;
      @(negedge clk);
      data = 8'hFF;
      @(negedge clk);
      send = 1'b0;
      wait_idle(200);

      // Reset in the middle of bit 3 of 0x3C.
      send = 1'b1;
      data = 8'h3C;
      @(negedge clk);
      send = 1'b0;
      repeat (1 + BIT + 3 * BIT + 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_tx",    tx,    1'b1);
      check("abort_busy",  busy,  1'b0);
      check("abort_ready", ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send = 1'b1;
      data = 8'h81;
      @(negedge clk);
      send = 1'b0;
      wait_idle(200);

      // Push on the pop edge while two bytes wait in IDLE.
      for (int i = 0; i < 3; i++) begin
         send = 1'b1;
         data = 8'($urandom);
         @(negedge clk);
      end
      send = 1'b0;
      hit  = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (!m_active && m_q.size() == 2) hit = 1'b1;
      end
      check("pushpop_reached", hit, 1'b1);
      send = 1'b1;
      data = 8'h5A;
      @(negedge clk);
      send = 1'b0;
      check("pushpop_ready", ready, 1'b1);
      wait_idle(400);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         send = ($urandom_range(0, 9) == 0);
         data = 8'($urandom);
         @(negedge clk);
      end
      send = 1'b0;
      wait_idle(400);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial UART transmitter with a small input FIFO. It is the outbound counterpart of the receive path and drives the top-level Tx pin.
- Accepts bytes from the top-level control logic over a Send/Ready handshake, buffers them, and serialises each byte as 8N1, LSB first.
- Bit timing matches the receiver's divider convention, so both directions run at the same baud from the 100 MHz clock.

Parameters:
- CNT_WIDTH, 14, width of the baud counter.
- BAUD_DIV, 14'd9999, terminal count. One bit period is BAUD_DIV+1 clocks (10 kbaud at 100 MHz).
- DEPTH, 4, FIFO depth in bytes. Must be a power of two, 2 or greater.
- ADDR_W, 2, log2(DEPTH).

Ports:
- Clk_100M  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Data  input  8  byte to transmit; sampled only on an accepted Send.
- Send  input  1  write request; a write is accepted at a clock edge when Send && Ready.
- Ready  output  1  FIFO not full (count != DEPTH).
- Busy  output  1  high while state != IDLE or FIFO count != 0.
- Tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset (Reset=0, asynchronous):
  - Tx=1, Ready=1, Busy=0.
  - FIFO pointers and count cleared; state=IDLE; baud counter and bit index cleared.
  - A frame in progress is aborted immediately; Tx returns high without waiting for a clock.
- FIFO:
  - Circular buffer with ADDR_W-bit read/write pointers that wrap modulo DEPTH; count is ADDR_W+1 bits.
  - Push on accepted Send; pop only in IDLE when count != 0.
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Send while Ready=0 is ignored: byte dropped, no state change, no error flag.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: Tx=1. If count != 0: load the head byte into an 8-bit shift register, pop, clear the baud counter, set Tx<=0, go to START.
  - START: hold Tx=0 for BAUD_DIV+1 clocks. At the terminal count: Tx<=shift[0], bit index=0, go to DATA.
  - DATA: each bit is held BAUD_DIV+1 clocks. At the terminal count, shift right and increment the bit index. After bit 7's period: Tx<=1, go to STOP.
  - STOP: hold Tx=1 for BAUD_DIV+1 clocks, then go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV and wraps to 0 on each bit boundary.
  - Cleared on every state entry from IDLE.
- Timing:
  - Accepted Send at edge k into an empty, idle block → Tx falls after edge k+1.
  - Frame length is exactly 10*(BAUD_DIV+1) clocks.
  - Back-to-back frames: STOP → IDLE → START, giving exactly one extra clock of Tx=1 between frames.
- Busy:
  - Combinational from state and count.
  - Goes high after the accepting edge.
  - Goes low the clock after STOP ends, provided the FIFO is empty.
- Data is never sampled outside an accepted Send. Holding Send high pushes one byte per clock until the FIFO is full.

Test Plan (run with BAUD_DIV=3 for a 4-clock bit period; DEPTH=4):
- Reset: hold Reset=0 with Send toggling → Tx=1, Ready=1, Busy=0 throughout; no FIFO writes.
- Single byte: Send 0xA5 for one clock → Tx falls one clock after acceptance, then shows 0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks total). Busy goes low 1 clock after the stop bit ends.
- Overflow: Send high for 6 consecutive clocks with bytes 0x01..0x06 while idle:
  - Bytes 0x01..0x05 accepted (first is popped on the 2nd edge).
  - Ready=0 after the 5th edge; 0x06 dropped.
  - Line carries 0x01..0x05 in order, each frame separated by exactly 1 extra high clock.
- Back-to-back: queue 0x00 and 0xFF → 0x00 frame (start plus 8 zeros, 36 low clocks), stop 4 clocks plus 1 idle clock high, then the 0xFF frame. Tx shows 4 low clocks (start) followed by 36 high clocks (data and stop).
- Reset mid-frame: assert Reset during bit 3 of 0x3C → Tx high with no clock edge, Busy=0, FIFO empty. After release, Send 0x81 transmits a clean frame with no residue of 0x3C.
- Simultaneous push/pop: with FIFO holding 2 bytes and state IDLE, Send on the pop edge → count stays 2, output order preserved.
